// File: rtl/ysyx_23060124_pipe_elastic_buf.sv
// Elastic IDU->EXU pipeline buffer: DEPTH-entry FIFO with valid/ready on both sides,
// flush for redirects, and a saturating count of downstream transfers.
module ysyx_23060124_pipe_elastic_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_flush,
  input  logic                       i_pre_valid,
  output logic                       o_pre_ready,
  input  logic [DATA_W-1:0]          i_data,
  output logic                       o_post_valid,
  input  logic                       i_post_ready,
  output logic [DATA_W-1:0]          o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [CNT_W-1:0]           o_xfer_cnt
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]  r_xfer_cnt;

  logic w_push;
  logic w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready and valid come only from the registered count: no combinational path across the stage.
  assign o_pre_ready  = (r_count < CW'(DEPTH));
  assign o_post_valid = (r_count != '0);
  assign o_data       = o_post_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count      = r_count;
  assign o_xfer_cnt   = r_xfer_cnt;

  assign w_push = i_pre_valid & o_pre_ready & ~i_flush;
  assign w_pop  = o_post_valid & i_post_ready & ~i_flush;

  // Storage is deliberately unreset; stale entries are masked by r_count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_xfer_cnt <= '0;
    end else if (i_flush) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
        if (r_xfer_cnt != '1) begin
          r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
        end
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule
